// File: rtl/t2t_pkg.sv
// Shared types and default widths for the RCB RAM port arbiter.
// Optional starvation monitor is enabled by defining RCB_ARB_STARVE_EN.
package t2t_pkg;

  localparam int T2T_RAM_WIDTH    = 64;
  localparam int T2T_ADDR_WIDTH   = 14;
  localparam int T2T_STARVE_LIMIT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HRD  = 2'd1,
    HRSP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rcb_arb_starve.sv
// Host wait-cycle counter with sticky starvation flag.
// Only instantiated when RCB_ARB_STARVE_EN is defined.
module rcb_arb_starve #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_cyc,
  input  logic accept,
  input  logic clr,
  output logic starved
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] count;
  logic          hit;

  // The flag fires on the increment that reaches the limit, so a clear
  // while still saturated is not immediately undone.
  assign hit = wait_cyc && (count == CW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      starved <= 1'b0;
    end else begin
      if (accept) begin
        count <= '0;
      end else if (wait_cyc && (count != CW'(STARVE_LIMIT))) begin
        count <= count + 1'b1;
      end
      if (hit) begin
        starved <= 1'b1;
      end else if (clr) begin
        starved <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rcb_port_arb.sv
// Arbiter for the shared RCB RAM port: strategy reads always win, host gets the rest.
// Define RCB_ARB_STARVE_EN to build the host starvation monitor.
module rcb_port_arb
  import t2t_pkg::*;
#(
  parameter int RAM_WIDTH    = T2T_RAM_WIDTH,
  parameter int ADDR_WIDTH   = T2T_ADDR_WIDTH,
  parameter int STARVE_LIMIT = T2T_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sef_read,
  input  logic [ADDR_WIDTH-1:0] t2t_rd_addr,
  output logic [RAM_WIDTH-1:0]  rcb_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [RAM_WIDTH-1:0]  host_wdata,
  output logic                  host_rvalid,
  input  logic                  host_rready,
  output logic [RAM_WIDTH-1:0]  host_rdata,
  output logic                  host_starved,
  input  logic                  host_starved_clr,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_wdata,
  input  logic [RAM_WIDTH-1:0]  ram_rdata
);

  arb_state_t state;
  logic       sef_pend;
  logic       accept;

  assign host_ready = host_valid & ~sef_read & (state == IDLE);
  assign accept     = host_valid & host_ready;

  assign ram_en    = sef_read | accept;
  assign ram_we    = accept & host_wr;
  assign ram_addr  = sef_read ? t2t_rd_addr : host_addr;
  assign ram_wdata = host_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sef_pend    <= 1'b0;
      rcb_data    <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      // RAM data returns one cycle after the strategy read was issued.
      sef_pend <= sef_read;
      if (sef_pend) begin
        rcb_data <= ram_rdata;
      end
      case (state)
        IDLE: begin
          if (accept && !host_wr) begin
            state <= HRD;
          end
        end
        HRD: begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
          state       <= HRSP;
        end
        HRSP: begin
          if (host_rready) begin
            host_rvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RCB_ARB_STARVE_EN
  rcb_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .wait_cyc (host_valid & ~host_ready & (state == IDLE)),
    .accept   (accept),
    .clr      (host_starved_clr),
    .starved  (host_starved)
  );
`else
  logic unused_starve;
  assign unused_starve = host_starved_clr ^ (STARVE_LIMIT == 0);
  assign host_starved  = 1'b0;
`endif

endmodule

// File: tb/tb_rcb_port_arb.sv
// Self-checking bench for rcb_port_arb: transaction-level model, directed cases, random traffic.
module tb_rcb_port_arb;

  localparam int RW = 64;
  localparam int AW = 14;
  localparam int SL = 16;
`ifdef RCB_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sef_read = 1'b0;
  logic [AW-1:0] t2t_rd_addr = '0;
  logic [RW-1:0] rcb_data;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [RW-1:0] host_wdata = '0;
  logic          host_rvalid;
  logic          host_rready = 1'b0;
  logic [RW-1:0] host_rdata;
  logic          host_starved;
  logic          host_starved_clr = 1'b0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata;
  logic [RW-1:0] ram_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  rcb_port_arb #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .sef_read(sef_read), .t2t_rd_addr(t2t_rd_addr),
    .rcb_data(rcb_data), .host_valid(host_valid), .host_ready(host_ready),
    .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rready(host_rready), .host_rdata(host_rdata),
    .host_starved(host_starved), .host_starved_clr(host_starved_clr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Simple synchronous RAM, one-cycle read latency
  logic [RW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Transaction-level model: memory image, pending strategy result,
  // host read progress (0 none, 1 in flight, 2 response offered).
  logic [RW-1:0] mem_m [0:15];
  logic [RW-1:0] m_rcb = '0, m_pend_val = '0, m_rval = '0, m_rdata = '0;
  logic          m_pend = 1'b0, m_starved = 1'b0, m_acc_q = 1'b0;
  int            m_phase = 0;
  int            m_cnt = 0;
  logic          m_acc_now;
  bit            checking = 1'b0;

  assign m_acc_now = host_valid && !sef_read && (m_phase == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_rcb <= '0; m_rdata <= '0; m_pend <= 1'b0;
      m_cnt <= 0; m_starved <= 1'b0; m_acc_q <= 1'b0;
    end else begin
      m_acc_q <= m_acc_now;
      if (m_pend) m_rcb <= m_pend_val;
      m_pend     <= sef_read;
      m_pend_val <= mem_m[t2t_rd_addr[3:0]];
      if (m_phase == 0 && m_acc_now && !host_wr) begin
        m_phase <= 1;
        m_rval  <= mem_m[host_addr[3:0]];
      end else if (m_phase == 1) begin
        m_phase <= 2;
        m_rdata <= m_rval;
      end else if (m_phase == 2 && host_rready) begin
        m_phase <= 0;
        $display("txn host rd data %h", m_rdata);
      end
      if (m_acc_now && host_wr) begin
        mem_m[host_addr[3:0]] <= host_wdata;
        $display("txn host wr addr %0d data %h", host_addr, host_wdata);
      end
      if (STARVE_ON) begin
        if (m_acc_now) m_cnt <= 0;
        else if (host_valid && m_phase == 0 && m_cnt < SL) m_cnt <= m_cnt + 1;
        if (host_valid && m_phase == 0 && !m_acc_now && m_cnt == SL - 1) m_starved <= 1'b1;
        else if (host_starved_clr) m_starved <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking && !reset) begin
      chk("host_ready", RW'(host_ready), RW'(m_acc_now));
      chk("ram_en", RW'(ram_en), RW'(sef_read || m_acc_now));
      chk("ram_we", RW'(ram_we), RW'(m_acc_now && host_wr));
      if (sef_read || m_acc_now)
        chk("ram_addr", RW'(ram_addr), RW'(sef_read ? t2t_rd_addr : host_addr));
      if (m_acc_now && host_wr) chk("ram_wdata", ram_wdata, host_wdata);
      chk("rcb_data", rcb_data, m_rcb);
      chk("host_rvalid", RW'(host_rvalid), RW'(m_phase == 2));
      chk("host_rdata", host_rdata, m_rdata);
      chk("host_starved", RW'(host_starved), RW'(m_starved));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    #2 reset = 1'b1;
    #20;
    chk("rst_rcb_data", rcb_data, '0);
    chk("rst_host_rvalid", RW'(host_rvalid), '0);
    chk("rst_host_rdata", host_rdata, '0);
    chk("rst_host_starved", RW'(host_starved), '0);
    reset = 1'b0;
    checking = 1'b1;

    // Write 1 and 5, then read 5 back
    cyc(); host_valid = 1; host_wr = 1; host_addr = 1; host_wdata = 64'hBEEF;
    cyc(); host_addr = 5; host_wdata = 64'hDEAD;
    #1 chk("wr_ready", RW'(host_ready), 1);
    cyc(); host_wr = 0; host_addr = 5;
    #1 chk("rd_ready", RW'(host_ready), 1);
    cyc(); host_valid = 0;
    #1 chk("hrd_rvalid", RW'(host_rvalid), 0);
    cyc();
    #1 chk("rsp_rvalid", RW'(host_rvalid), 1);
    chk("rsp_rdata", host_rdata, 64'hDEAD);
    host_rready = 1;
    cyc(); host_rready = 0;

    // Strategy read collides with host read
    sef_read = 1; t2t_rd_addr = 5; host_valid = 1; host_wr = 0; host_addr = 5;
    #1 chk("coll_ready", RW'(host_ready), 0);
    chk("coll_addr", RW'(ram_addr), 5);
    cyc(); sef_read = 0;
    #1 chk("coll_accept", RW'(host_ready), 1);
    cyc(); host_valid = 0;
    #1 chk("coll_rcb", rcb_data, 64'hDEAD);
    cyc();
    #1 chk("coll_rdata", host_rdata, 64'hDEAD);

    // Response held while strategy reads of address 1 keep flowing
    for (int i = 0; i < 5; i++) begin
      cyc(); sef_read = (i % 2 == 0); t2t_rd_addr = 1; host_valid = 1; host_wr = 1; host_addr = 9;
      #1 chk("hold_ready", RW'(host_ready), 0);
      chk("hold_rdata", host_rdata, 64'hDEAD);
      chk("hold_rvalid", RW'(host_rvalid), 1);
    end
    cyc(); sef_read = 0; host_valid = 0;
    cyc();
    #1 chk("hold_rcb", rcb_data, 64'hBEEF);
    host_rready = 1;
    cyc(); host_rready = 0;

    // Sixteen blocked cycles, then clear
    host_valid = 1; host_wr = 1; host_addr = 7; host_wdata = 64'h1234; sef_read = 1; t2t_rd_addr = 2;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        #1 chk("starve_early", RW'(host_starved), 0);
      end
      cyc();
    end
    host_starved_clr = 1;
    #1 chk("starve_set", RW'(host_starved), RW'(STARVE_ON));
    cyc(); sef_read = 0; host_starved_clr = 0;
    #1 chk("starve_clr", RW'(host_starved), 0);
    cyc(); host_valid = 0;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (!host_valid || m_acc_q) begin
        host_valid = ($urandom_range(0, 2) != 0);
        host_wr    = 1'($urandom_range(0, 1));
        host_addr  = AW'($urandom_range(0, 15));
        host_wdata = {$urandom, $urandom};
      end
      sef_read         = ($urandom_range(0, 3) == 0);
      t2t_rd_addr      = AW'($urandom_range(0, 15));
      host_rready      = 1'($urandom_range(0, 1));
      host_starved_clr = ($urandom_range(0, 15) == 0);
    end
    cyc(); host_valid = 0; sef_read = 0; host_rready = 1; host_starved_clr = 0;
    for (int i = 0; i < 4; i++) cyc();
    host_rready = 0;

    // Reset while a response is offered
    host_valid = 1; host_wr = 0; host_addr = 3;
    cyc(); host_valid = 0;
    cyc();
    #1 chk("pre_rst_rvalid", RW'(host_rvalid), 1);
    reset = 1'b1;
    #1 chk("rst_hrsp_rvalid", RW'(host_rvalid), 0);
    chk("rst_hrsp_rdata", host_rdata, '0);
    chk("rst_hrsp_rcb", rcb_data, '0);
    #1 reset = 1'b0;
    cyc(); host_valid = 1;
    #1 chk("post_rst_ready", RW'(host_ready), 1);
    cyc(); host_valid = 0; host_rready = 1;
    for (int i = 0; i < 4; i++) cyc();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
